card_board_renderer: RTL

- Requester side of the card sprite lookup: walks the VGA raster, decides which board slot (if any) covers each pixel, and issues pixel_x/pixel_y/card_type to the sprite-memory pixel reader.
- Realigns the returned card_pixel with the raster and produces final RGB.
- Holds the board layout as a slot table with tear-free, frame-synchronous commit.
- Sits between the VGA timing counters and the VGA output register.

---
 rtl/card_board_renderer_pkg.sv | 47 ++++
 rtl/card_slot_table.sv | 61 ++++++
 rtl/card_board_renderer.sv | 97 +++++++++
 3 files changed

// File: rtl/card_board_renderer_pkg.sv
// Shared display constants and the raster-to-slot locator used by the card board renderer.
package card_board_renderer_pkg;

    localparam int COLS      = 16;
    localparam int ROWS      = 6;
    localparam int NUM_SLOTS = COLS * ROWS;
    localparam int ORIGIN_X  = 48;
    localparam int ORIGIN_Y  = 96;
    localparam int PITCH_X   = 36;
    localparam int PITCH_Y   = 50;
    localparam int V_SWAP    = 480;
    localparam int CARD_W    = 32;
    localparam int CARD_H    = 46;

    localparam logic [5:0]  EMPTY_CARD    = 6'd63;
    localparam logic [5:0]  FIRST_INVALID = 6'd54;
    localparam logic [11:0] BG_COLOR      = 12'h68A;

    typedef logic [5:0] card_t;

    typedef struct packed {
        logic       hit;
        logic [6:0] idx;
        logic [5:0] lx;
        logic [5:0] ly;
    } locate_t;

    // Constant-divisor divide/modulo on 10-bit operands: shallow enough for a 40 ns cycle.
    function automatic locate_t locate(input logic [9:0] h, input logic [9:0] v, input logic vld);
        logic [9:0] dx, dy, col, row, lx, ly;
        locate_t    r;
        dx    = h - 10'(ORIGIN_X);
        dy    = v - 10'(ORIGIN_Y);
        col   = dx / 10'(PITCH_X);
        row   = dy / 10'(PITCH_Y);
        lx    = dx % 10'(PITCH_X);
        ly    = dy % 10'(PITCH_Y);
        r.hit = vld && (h >= 10'(ORIGIN_X)) && (v >= 10'(ORIGIN_Y)) &&
                (col < 10'(COLS)) && (row < 10'(ROWS)) &&
                (lx < 10'(CARD_W)) && (ly < 10'(CARD_H));
        r.idx = 7'(row * 10'(COLS) + col);
        r.lx  = lx[5:0];
        r.ly  = ly[5:0];
        return r;
    endfunction

endpackage

// File: rtl/card_slot_table.sv
// Double-buffered board layout: writes go to the shadow table, and a pending commit copies
// shadow to active in one edge during vertical blanking so a frame never shows a half-updated board.
module card_slot_table
    import card_board_renderer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [6:0] wr_idx,
    input  logic [5:0] wr_card,
    input  logic       commit,
    input  logic       valid,
    input  logic [9:0] v_cnt,
    input  logic [6:0] rd_idx,
    output logic [5:0] rd_card,
    output logic       commit_done
);

    card_t shadow_q [NUM_SLOTS];
    card_t active_q [NUM_SLOTS];
    logic  pending_q, pending_d;
    logic  commit_done_q;
    logic  swap;

    assign swap = pending_q && !valid && (v_cnt == 10'(V_SWAP));

    // NOTE: default first so every path assigns pending_d; otherwise always_comb infers a latch.
    always_comb begin
        pending_d = pending_q;
        if (swap)
            pending_d = 1'b0;
        else if (commit)
            pending_d = 1'b1;
    end

    // NOTE: the tables are flop arrays, not RAM, so they can be (and must be) cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= 1'b0;
            commit_done_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow_q[i] <= EMPTY_CARD;
                active_q[i] <= EMPTY_CARD;
            end
        end else begin
            // NOTE: non-blocking, so a swap copies the shadow value from before this edge's write.
            pending_q     <= pending_d;
            commit_done_q <= swap;
            if (swap) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    active_q[i] <= shadow_q[i];
            end
            if (wr_en && (wr_idx < 7'(NUM_SLOTS)))
                shadow_q[wr_idx] <= wr_card;
        end
    end

    assign rd_card     = (rd_idx < 7'(NUM_SLOTS)) ? active_q[rd_idx] : EMPTY_CARD;
    assign commit_done = commit_done_q;

endmodule

// File: rtl/card_board_renderer.sv
// Raster-side card renderer: maps each pixel to a board slot, requests the sprite pixel,
// and composes the final colour with a fixed three-cycle latency.
module card_board_renderer
    import card_board_renderer_pkg::*;
(
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        wr_en,
    input  logic [6:0]  wr_idx,
    input  logic [5:0]  wr_card,
    input  logic        commit,
    output logic        commit_done,
    output logic [5:0]  pixel_x,
    output logic [5:0]  pixel_y,
    output logic [5:0]  card_type,
    input  logic [11:0] card_pixel,
    output logic [11:0] rgb,
    output logic        rgb_valid
);

    locate_t     loc;
    card_t       rd_card;
    logic [5:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    card_t       card_type_q, card_type_d;
    logic        s1_hit_q, s1_valid_q;
    logic        s2_drawable_q, s2_valid_q;
    logic [11:0] rgb_q, rgb_d;
    logic        rgb_valid_q;

    assign loc = locate(h_cnt, v_cnt, valid);

    card_slot_table u_table (
        .clk         (clk_25MHz),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_card     (wr_card),
        .commit      (commit),
        .valid       (valid),
        .v_cnt       (v_cnt),
        .rd_idx      (loc.idx),
        .rd_card     (rd_card),
        .commit_done (commit_done)
    );

    always_comb begin
        pixel_x_d   = '0;
        pixel_y_d   = '0;
        card_type_d = EMPTY_CARD;
        if (loc.hit) begin
            pixel_x_d   = loc.lx;
            pixel_y_d   = loc.ly;
            card_type_d = rd_card;
        end
    end

    // card_pixel answers the stage-1 request one cycle later, so the stage-2 flags line up with it.
    always_comb begin
        rgb_d = s2_valid_q ? BG_COLOR : 12'h000;
        if (s2_drawable_q)
            rgb_d = card_pixel;
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            card_type_q   <= EMPTY_CARD;
            s1_hit_q      <= 1'b0;
            s1_valid_q    <= 1'b0;
            s2_drawable_q <= 1'b0;
            s2_valid_q    <= 1'b0;
            rgb_q         <= '0;
            rgb_valid_q   <= 1'b0;
        end else begin
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            card_type_q   <= card_type_d;
            s1_hit_q      <= loc.hit;
            s1_valid_q    <= valid;
            s2_drawable_q <= s1_hit_q && (card_type_q < FIRST_INVALID);
            s2_valid_q    <= s1_valid_q;
            rgb_q         <= rgb_d;
            rgb_valid_q   <= s2_valid_q;
        end
    end

    assign pixel_x   = pixel_x_q;
    assign pixel_y   = pixel_y_q;
    assign card_type = card_type_q;
    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;

endmodule
